// File: rtl/serial_add_sched_pkg.sv
// Shared types and helpers for the serial slice-add scheduler.
// State encodings are fixed so waveforms stay readable across the DCT datapath.
package serial_add_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int SLICE_W = 8;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_add_sched_slice_add8.sv
// 8-bit kgp recursive-doubling (Kogge-Stone) slice adder.
// Carry-in is folded into the bit-0 generate at the prefix root.
module slice_add8
  import serial_add_sched_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  localparam int LVL = $clog2(SLICE_W);

  logic [SLICE_W-1:0] pg;
  logic [SLICE_W-1:0] gl;
  logic [SLICE_W-1:0] pl;
  logic [SLICE_W-1:0] gn;
  logic [SLICE_W-1:0] pn;

  always_comb begin
    pg    = a ^ b;
    gl    = a & b;
    gl[0] = gl[0] | (pg[0] & cin);
    pl    = pg;
    gn    = gl;
    pn    = pl;
    for (int l = 0; l < LVL; l++) begin
      gn = gl;
      pn = pl;
      for (int i = (1 << l); i < SLICE_W; i++) begin
        gn[i] = gl[i] | (pl[i] & gl[i - (1 << l)]);
        pn[i] = pl[i] & pl[i - (1 << l)];
      end
      gl = gn;
      pl = pn;
    end
    // gl[i] is now the carry out of bit i
    sum  = pg ^ {gl[SLICE_W-2:0], cin};
    cout = gl[SLICE_W-1];
  end

endmodule

// File: rtl/serial_add_sched.sv
// Two-requester round-robin scheduler sequencing one wide add
// through a single shared 8-bit slice adder, LSB slice first.
module serial_add_sched
  import serial_add_sched_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [1:0]       req_cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_carry,
  output logic             res_id,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = cnt_width(NSLICE);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(NSLICE - 1);

  generate
    if ((WIDTH % SLICE) != 0) begin : g_bad_width
      $error("WIDTH must be a multiple of SLICE");
    end
    if (SLICE != SLICE_W) begin : g_bad_slice
      $error("SLICE must match the slice adder width");
    end
  endgenerate

  state_e             state_q, state_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               rc_q, rc_d;
  logic               id_q, id_d;

  logic               gnt;
  logic               hs;
  int                 base;
  logic [SLICE-1:0]   sl_a;
  logic [SLICE-1:0]   sl_b;
  logic [SLICE-1:0]   sl_s;
  logic               sl_c;

  // Contention goes to whoever did not win last time
  always_comb begin
    gnt = 1'b0;
    unique case (req_valid)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last_q;
      default: gnt = 1'b0;
    endcase
    hs = (state_q == IDLE) && (|req_valid) && !rst;
    req_ready = 2'b00;
    if (hs) req_ready[gnt] = 1'b1;
  end

  always_comb begin
    base = int'(cnt_q) * SLICE;
    sl_a = a_q[base +: SLICE];
    sl_b = b_q[base +: SLICE];
  end

  slice_add8 u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .sum  (sl_s),
    .cout (sl_c)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    rc_d    = rc_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = RUN;
          a_d     = gnt ? req_a1 : req_a0;
          b_d     = gnt ? req_b1 : req_b0;
          carry_d = req_cin[gnt];
          id_d    = gnt;
          last_d  = gnt;
          cnt_d   = '0;
        end
      end
      RUN: begin
        sum_d[base +: SLICE] = sl_s;
        carry_d = sl_c;
        if (cnt_q == LAST) begin
          rc_d    = sl_c;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      rc_q    <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      rc_q    <= rc_d;
      id_q    <= id_d;
    end
  end

  assign res_valid = (state_q == DONE);
  assign res_sum   = sum_q;
  assign res_carry = rc_q;
  assign res_id    = id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_add_sched.sv
// Self-checking bench for serial_add_sched.
// Expected results come from plain wide arithmetic and a grant model.
module tb_serial_add_sched;

  localparam int W = 48;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]   req_cin;
  logic         res_valid, res_ready;
  logic [W-1:0] res_sum;
  logic         res_carry, res_id, busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_add_sched #(.WIDTH(W), .SLICE(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_b0    (req_b0),
    .req_a1    (req_a1),
    .req_b1    (req_b1),
    .req_cin   (req_cin),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_carry (res_carry),
    .res_id    (res_id),
    .busy      (busy)
  );

  function automatic logic [W:0] model_add(
    input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  function automatic logic [W-1:0] rnd48();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic c);
    if (p == 0) begin
      req_a0 = a;
      req_b0 = b;
    end else begin
      req_a1 = a;
      req_b1 = b;
    end
    req_cin[p]   = c;
    req_valid[p] = 1'b1;
  endtask

  task automatic wait_grant(input int p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (req_ready[p]) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_done(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
      step();
      n++;
    end
  endtask

  task automatic ack();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic run_op(input int p, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic c,
                        output bit ok, output int lat,
                        output logic [W-1:0] s, output logic co,
                        output logic id);
    bit ok1, ok2;
    int n;
    drive(p, a, b, c);
    wait_grant(p, ok1);
    step();
    req_valid[p] = 1'b0;
    wait_done(n, ok2);
    lat = n + 1;
    s   = res_sum;
    co  = res_carry;
    id  = res_id;
    ok  = ok1 & ok2;
    ack();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [W+5:0] obs;
    req_valid = 2'b00;
    rst = 1'b1;
    step();
    step();
    obs = {req_ready, res_valid, res_sum, res_carry, res_id, busy};
    n_cmp++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got=%h want=0", obs);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if ({busy, res_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_idle got=%b want=00", {busy, res_valid});
    end
  endtask

  task automatic test_basic();
    bit ok;
    int lat;
    logic [W-1:0] s;
    logic co, id;
    run_op(0, 48'h0000000000FF, 48'h000000000001, 1'b0,
           ok, lat, s, co, id);
    n_cmp++;
    if ({ok, lat} !== {1'b1, 32'd7}) begin
      n_err++;
      $display("FAIL t1_latency got=%0d ok=%0b want=7", lat, ok);
    end
    n_cmp++;
    if ({s, co, id} !== {48'h000000000100, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL t1_result got=%h/%b/%b want=100/0/0", s, co, id);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL t1_idle_after_ack got=%b want=0", busy);
    end
    run_op(1, 48'hFFFFFFFFFFFF, 48'h000000000001, 1'b0,
           ok, lat, s, co, id);
    n_cmp++;
    if ({ok, s, co, id} !== {1'b1, 48'h0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL t2_carry_chain got=%h/%b/%b ok=%b want=0/1/1",
               s, co, id, ok);
    end
    run_op(0, 48'h123456789ABC, 48'hFFFFFFFFFFFF, 1'b1,
           ok, lat, s, co, id);
    n_cmp++;
    if ({ok, s, co, id} !== {1'b1, 48'h123456789ABC, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL t5_sub_zero got=%h/%b/%b ok=%b want=123456789abc/1/0",
               s, co, id, ok);
    end
  endtask

  task automatic test_contention();
    logic [W-1:0] oa [2];
    logic [W-1:0] ob [2];
    logic         oc [2];
    logic         last;
    logic         g, exp_g;
    logic [W:0]   e;
    bit           ok;
    int           n;
    for (int p = 0; p < 2; p++) begin
      oa[p] = rnd48();
      ob[p] = rnd48();
      oc[p] = 1'($urandom_range(1));
      drive(p, oa[p], ob[p], oc[p]);
    end
    do_reset();
    last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
        #1;
        if (req_ready != 2'b00) begin
          ok = 1'b1;
          break;
        end
        step();
      end
      n_cmp++;
      if (!ok || req_ready === 2'b11) begin
        n_err++;
        $display("FAIL t3_ready_onehot k=%0d got=%b", k, req_ready);
      end
      g = req_ready[1];
      exp_g = (req_valid == 2'b11) ? ~last : req_valid[1];
      last = exp_g;
      n_cmp++;
      if (g !== exp_g) begin
        n_err++;
        $display("FAIL t3_grant k=%0d got=%b want=%b", k, g, exp_g);
      end
      e = model_add(oa[g], ob[g], oc[g]);
      step();
      req_valid[g] = 1'b0;
      if (k == 0) begin
        oa[0] = rnd48();
        ob[0] = rnd48();
        oc[0] = 1'($urandom_range(1));
        drive(0, oa[0], ob[0], oc[0]);
      end
      wait_done(n, ok);
      n_cmp++;
      if ({ok, res_carry, res_sum, res_id} !== {1'b1, e, g}) begin
        n_err++;
        $display("FAIL t3_result k=%0d got=%b%h id=%b want=%h id=%b",
                 k, res_carry, res_sum, res_id, e, g);
      end
      ack();
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] a, b;
    logic         c;
    logic [W:0]   e;
    logic [W+1:0] snap;
    bit           ok;
    int           n;
    a = rnd48();
    b = rnd48();
    c = 1'($urandom_range(1));
    drive(0, a, b, c);
    wait_grant(0, ok);
    step();
    req_valid[0] = 1'b0;
    wait_done(n, ok);
    snap = {res_sum, res_carry, res_id};
    a = rnd48();
    b = rnd48();
    c = 1'($urandom_range(1));
    e = model_add(a, b, c);
    drive(1, a, b, c);
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if ({res_valid, req_ready, res_sum, res_carry, res_id} !==
          {1'b1, 2'b00, snap}) begin
        n_err++;
        $display("FAIL t4_hold cyc=%0d got=%b/%b/%h want=1/00/%h",
                 i, res_valid, req_ready, {res_sum, res_carry, res_id},
                 snap);
      end
    end
    ack();
    n_cmp++;
    if ({busy, res_valid, req_ready} !== 4'b0010) begin
      n_err++;
      $display("FAIL t4_idle got=%b want=0010",
               {busy, res_valid, req_ready});
    end
    step();
    req_valid[1] = 1'b0;
    wait_done(n, ok);
    n_cmp++;
    if ({ok, res_carry, res_sum, res_id} !== {1'b1, e, 1'b1}) begin
      n_err++;
      $display("FAIL t4_pending got=%b%h id=%b want=%h id=1",
               res_carry, res_sum, res_id, e);
    end
    ack();
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int n;
    bit seen;
    drive(0, 48'h0000000000FF, 48'h000000000001, 1'b0);
    wait_grant(0, ok);
    step();
    step();
    step();
    step();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL t6_running got=%b want=1", busy);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({req_ready, res_valid, res_sum, res_carry, res_id, busy} !== '0)
    begin
      n_err++;
      $display("FAIL t6_async_clear got=%b/%b/%h/%b/%b/%b want=0",
               req_ready, res_valid, res_sum, res_carry, res_id, busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (res_valid !== 1'b0 || req_ready !== 2'b00) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_err++;
      $display("FAIL t6_quiet_in_reset got=1 want=0");
    end
    rst = 1'b0;
    wait_grant(0, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL t6_reaccept got=timeout want=grant");
    end
    step();
    req_valid[0] = 1'b0;
    wait_done(n, ok);
    n_cmp++;
    if ({ok, res_sum, res_carry, res_id} !==
        {1'b1, 48'h000000000100, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL t6_result got=%h/%b/%b want=100/0/0",
               res_sum, res_carry, res_id);
    end
    ack();
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, s;
    logic         c, co, id;
    logic [W:0]   e;
    int           p, lat;
    bit           ok;
    for (int k = 0; k < 16; k++) begin
      p = int'($urandom_range(1));
      a = rnd48();
      b = (k % 4 == 0) ? ~a : rnd48();
      c = 1'($urandom_range(1));
      e = model_add(a, b, c);
      run_op(p, a, b, c, ok, lat, s, co, id);
      n_cmp++;
      if ({ok, lat, co, s, id} !== {1'b1, 32'd7, e, 1'(p)}) begin
        n_err++;
        $display("FAIL rand k=%0d got=%b%h id=%b lat=%0d want=%h id=%0d",
                 k, co, s, id, lat, e, p);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 2'b00;
    req_cin   = 2'b00;
    req_a0    = '0;
    req_b0    = '0;
    req_a1    = '0;
    req_b1    = '0;
    res_ready = 1'b0;
    test_reset();
    test_basic();
    test_contention();
    test_stall();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
